// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for a multicycle RV32-style datapath. Each instruction
// walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Memory handshakes in FETCH
// and MEM are guarded by a wait counter. An illegal opcode or a memory that
// never answers sends the FSM to TRAP, and it stays there until reset.
//
// Parameters
//   MEM_TIMEOUT   number of consecutive wait cycles tolerated on a memory
//                 handshake before trapping; 0 disables the timeout
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   opcode        instruction[6:0] from the instruction register
//   mem_ready     memory accepts/completes the current request
//   branch_taken  ALU branch comparison result (used in EXEC only)
//   mem_req       memory request, held until mem_ready
//   mem_we        memory write enable, qualified by mem_req
//   mem_addr_sel  memory address select: 0=PC, 1=ALU result
//   ir_write      load the instruction register
//   pc_write      update PC
//   pc_src        PC source: 0=PC+4, 1=branch/jump target
//   alu_op        00=add, 01=branch compare, 10=funct decode, 11=jump/pass
//   reg_write     register file write enable
//   mem_to_reg    writeback data select: 1=load data
//   state_o       current state encoding
//   trap          sticky fault flag
//   trap_cause    0=illegal opcode, 1=memory timeout
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [2:0] state_o,
    output logic       trap,
    output logic       trap_cause
);

    // State encodings
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    // Supported opcodes
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_IA = 7'b0010011;
    localparam logic [6:0] OP_IL = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_U  = 7'b0110111;
    localparam logic [6:0] OP_J  = 7'b1101111;

    // ALU operation codes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BRCMP = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASS  = 2'b11;

    // With the timeout disabled clog2(1) would be zero bits wide, so keep at
    // least one bit; the counter then simply saturates at all-ones.
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX =
        (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT) : {CNT_W{1'b1}};

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             trap_q;
    logic             cause_q;
    logic             set_trap;
    logic             set_cause;
    logic             in_handshake;
    logic             timeout_hit;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_IA, OP_IL, OP_S, OP_B, OP_U, OP_J: is_legal = 1'b1;
            default:                                    is_legal = 1'b0;
        endcase
    endfunction

    assign in_handshake = (state == ST_FETCH) || (state == ST_MEM);

    // The timeout fires in the cycle where the counter already holds
    // MEM_TIMEOUT and memory is still not ready; a ready in that same cycle
    // wins and completes the handshake normally.
    assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt == CNT_MAX) && !mem_ready;

    // Next-state logic and trap request
    always_comb begin
        state_next = state;
        set_trap   = 1'b0;
        set_cause  = 1'b0;
        case (state)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    state_next = ST_TRAP;
                    set_trap   = 1'b1;
                    set_cause  = 1'b1;
                end
            end
            ST_DECODE: begin
                // Decide on the live opcode; op_q is loaded on this same edge.
                if (is_legal(opcode)) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_TRAP;
                    set_trap   = 1'b1;
                    set_cause  = 1'b0;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_R, OP_IA, OP_U, OP_J: state_next = ST_WB;
                    OP_IL, OP_S:             state_next = ST_MEM;
                    default:                 state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_next = (op_q == OP_IL) ? ST_WB : ST_FETCH;
                end else if (timeout_hit) begin
                    state_next = ST_TRAP;
                    set_trap   = 1'b1;
                    set_cause  = 1'b1;
                end
            end
            ST_WB:   state_next = ST_FETCH;
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_FETCH;
        endcase
    end

    // Wait counter: counts stalled handshake cycles, clears on any progress
    // and saturates instead of wrapping.
    always_comb begin
        wait_cnt_next = wait_cnt;
        if ((state_next != state) || mem_ready || !in_handshake) begin
            wait_cnt_next = '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
            cause_q  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state == ST_DECODE) begin
                op_q <= opcode;
            end
            if (set_trap) begin
                trap_q  <= 1'b1;
                cause_q <= set_cause;
            end
        end
    end

    // Control outputs are a pure function of state (plus mem_ready in FETCH
    // and branch_taken in EXEC). Gating with rst_n drops the request and the
    // write enables immediately when reset asserts, even mid-handshake.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_op       = ALU_ADD;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_R, OP_IA, OP_U: alu_op = ALU_FUNCT;
                    OP_B: begin
                        alu_op   = ALU_BRCMP;
                        pc_write = branch_taken;
                        pc_src   = 1'b1;
                    end
                    OP_J: begin
                        alu_op   = ALU_PASS;
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op_q == OP_S);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_IL);
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
        if (!rst_n) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = 1'b0;
            alu_op       = ALU_ADD;
            reg_write    = 1'b0;
            mem_to_reg   = 1'b0;
        end
    end

    assign state_o    = state;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Scoreboard bench for multicycle_control (MEM_TIMEOUT=4). An instruction
// level reference model turns each instruction (opcode, fetch wait count,
// memory wait count, branch outcome) into the per-cycle input vectors to
// drive and the per-cycle output records the controller must show. A driver
// plays the inputs back; an independent monitor pops and compares one
// expected record every cycle the driver marks as live.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int T = 4;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_IA = 7'b0010011;
    localparam logic [6:0] OP_IL = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_U  = 7'b0110111;
    localparam logic [6:0] OP_J  = 7'b1101111;

    typedef struct packed {
        logic [6:0] op;
        logic       rdy;
        logic       bt;
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       asel;
        logic       irw;
        logic       pcw;
        logic       pcs;
        logic [1:0] alu;
        logic       rw;
        logic       m2r;
        logic       trp;
        logic       cause;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic [2:0] state_o;
    logic       trap;
    logic       trap_cause;

    stim_t stimQ[$];
    out_t  expQ[$];
    int    checks = 0;
    int    failures = 0;
    bit    cycle_valid = 1'b0;

    logic [6:0] legalOps [7] = '{OP_R, OP_IA, OP_IL, OP_S, OP_B, OP_U, OP_J};

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .state_o      (state_o),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    // ---------------- reference model ----------------

    function automatic out_t blank(input logic [2:0] st);
        out_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic randBit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] randOp();
        return 7'($urandom());
    endfunction

    function automatic bit isLegal(input logic [6:0] op);
        foreach (legalOps[i]) if (legalOps[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic pushCycle(input out_t e, input logic [6:0] op, input logic rdy, input logic bt);
        stim_t s;
        s.op  = op;
        s.rdy = rdy;
        s.bt  = bt;
        stimQ.push_back(s);
        expQ.push_back(e);
    endtask

    // The machine sits in TRAP forever, whatever the inputs do.
    task automatic addTrap(input int n, input logic cause);
        out_t e;
        for (int k = 0; k < n; k++) begin
            e       = blank(3'd5);
            e.trp   = 1'b1;
            e.cause = cause;
            pushCycle(e, randOp(), randBit(), randBit());
        end
    endtask

    // A memory handshake answered after `waits` stalled cycles. Up to T stalls
    // are tolerated (ready may arrive in the cycle after the T-th stall); a
    // memory that stays silent longer ends in a timeout after T+1 cycles.
    task automatic handshake(input bit isMem, input bit isStore, input int waits, output bit done);
        out_t e;
        logic rdy;
        int   n;
        n = (waits > T) ? T + 1 : waits + 1;
        for (int k = 0; k < n; k++) begin
            rdy    = (waits <= T) && (k == waits);
            e      = blank(isMem ? 3'd3 : 3'd0);
            e.req  = 1'b1;
            e.asel = isMem;
            e.we   = isMem && isStore;
            if (!isMem) begin
                e.irw = rdy;
                e.pcw = rdy;
            end
            pushCycle(e, randOp(), rdy, randBit());
        end
        done = (waits <= T);
    endtask

    task automatic modelInstr(input logic [6:0] op, input int wf, input int wm,
                              input logic bt, input int trapTail);
        out_t e;
        bit   done;
        handshake(1'b0, 1'b0, wf, done);
        if (!done) begin
            addTrap(trapTail, 1'b1);
            return;
        end
        pushCycle(blank(3'd1), op, randBit(), randBit());
        if (!isLegal(op)) begin
            addTrap(trapTail, 1'b0);
            return;
        end
        e = blank(3'd2);
        case (op)
            OP_IL, OP_S: e.alu = 2'b00;
            OP_B: begin
                e.alu = 2'b01;
                e.pcw = bt;
                e.pcs = 1'b1;
            end
            OP_J: begin
                e.alu = 2'b11;
                e.pcw = 1'b1;
                e.pcs = 1'b1;
            end
            default: e.alu = 2'b10;
        endcase
        pushCycle(e, randOp(), randBit(), (op == OP_B) ? bt : randBit());
        if (op == OP_B) return;
        if (op == OP_IL || op == OP_S) begin
            handshake(1'b1, op == OP_S, wm, done);
            if (!done) begin
                addTrap(trapTail, 1'b1);
                return;
            end
            if (op == OP_S) return;
        end
        e     = blank(3'd4);
        e.rw  = 1'b1;
        e.m2r = (op == OP_IL);
        pushCycle(e, randOp(), randBit(), randBit());
    endtask

    // ---------------- checking ----------------

    task automatic checkOutput(input string name, input out_t e);
        out_t a;
        a.st    = state_o;
        a.req   = mem_req;
        a.we    = mem_we;
        a.asel  = mem_addr_sel;
        a.irw   = ir_write;
        a.pcw   = pc_write;
        a.pcs   = pc_src;
        a.alu   = alu_op;
        a.rw    = reg_write;
        a.m2r   = mem_to_reg;
        a.trp   = trap;
        a.cause = trap_cause;
        checks++;
        if (a !== e) begin
            failures++;
            $display("[TB] FAIL %s @%0t: got st=%0d ctl=%b, expected st=%0d ctl=%b (req we asel irw pcw pcs alu rw m2r trap cause)",
                     name, $time, a.st, a[11:0], e.st, e[11:0]);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s @%0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    // Monitor: one expected record per live cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (cycle_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard_underflow @%0t: got a live cycle, expected none", $time);
            end else begin
                checkOutput("cycle", expQ.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------

    // Hold reset and confirm all controls stay low while it is asserted.
    task automatic doReset();
        rst_n       = 1'b0;
        cycle_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_ready = randBit();
            @(negedge clk);
            checkOutput("reset", blank(3'd0));
        end
    endtask

    // Release reset (if held) and play back every queued input vector.
    task automatic applyStimulus();
        stim_t s;
        while (stimQ.size() > 0) begin
            @(posedge clk);
            #1;
            s            = stimQ.pop_front();
            opcode       = s.op;
            mem_ready    = s.rdy;
            branch_taken = s.bt;
            rst_n        = 1'b1;
            cycle_valid  = 1'b1;
        end
        @(posedge clk);
        #1;
        cycle_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog @%0t: got no completion, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        opcode       = '0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        doReset();

        $display("[TB] directed instruction mix");
        modelInstr(OP_R,  0, 0, 1'b0, 0);
        modelInstr(OP_IL, 0, 3, 1'b0, 0);
        modelInstr(OP_B,  0, 0, 1'b1, 0);
        modelInstr(OP_B,  0, 0, 1'b0, 0);
        modelInstr(OP_S,  1, 2, 1'b0, 0);
        modelInstr(OP_IA, 2, 0, 1'b0, 0);
        modelInstr(OP_U,  0, 0, 1'b0, 0);
        modelInstr(OP_J,  0, 0, 1'b0, 0);
        modelInstr(OP_R,  T, 0, 1'b0, 0);
        modelInstr(OP_IL, 1, T, 1'b0, 0);
        modelInstr(OP_S,  T, T, 1'b0, 0);
        applyStimulus();
        doReset();

        $display("[TB] illegal opcode");
        modelInstr(7'b1111111, 0, 0, 1'b0, 22);
        applyStimulus();
        doReset();

        $display("[TB] fetch timeout");
        modelInstr(OP_R, T + 1, 0, 1'b0, 6);
        applyStimulus();
        doReset();

        $display("[TB] memory timeout on load");
        modelInstr(OP_IL, 0, T + 1, 1'b0, 6);
        applyStimulus();
        doReset();

        for (int seg = 0; seg < 3; seg++) begin
            $display("[TB] random segment %0d", seg);
            for (int i = 0; i < 20; i++) begin
                modelInstr(legalOps[$urandom_range(0, 6)], $urandom_range(0, T),
                           $urandom_range(0, T), randBit(), 0);
            end
            applyStimulus();
            doReset();
        end

        $display("[TB] reset in the middle of a store");
        modelInstr(OP_S, 0, 3, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            void'(stimQ.pop_back());
            void'(expQ.pop_back());
        end
        applyStimulus();
        mem_ready = 1'b0;
        #3;
        checkBit("store_req_before_reset", mem_req, 1'b1);
        checkBit("store_we_before_reset", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        checkBit("store_req_async_drop", mem_req, 1'b0);
        checkBit("store_we_async_drop", mem_we, 1'b0);
        checkBit("state_fetch_in_reset", state_o == 3'd0, 1'b1);
        doReset();
        modelInstr(OP_R, 0, 0, 1'b0, 0);
        modelInstr(OP_IL, 0, 0, 1'b0, 0);
        applyStimulus();
        doReset();

        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_leftover: got %0d pending, expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
